// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared constants for the PS/2 arrow-key front end: scan
//               codes, receiver state encoding and direction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Scan codes of interest (set 2)
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Receiver FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Direction encoding; the value doubles as the bit index in the one-hot
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // One-hot {right, left, down, up} for a direction
    function automatic logic [3:0] dir_onehot(input dir_e d);
        dir_onehot = 4'b0001 << d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host receiver. Synchronises the raw pins,
//               glitch-filters the PS/2 clock, frames 11-bit words and
//               aborts stalled frames after a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Synchroniser stages (pins idle high)
    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    // Glitch filter
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    // Receiver
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_valid_q, byte_valid_d;
    logic          err_q, err_d;

    // Two-flop synchronisers for both pins
    always_comb begin
        clk_meta_d = ps2_clk;
        clk_sync_d = clk_meta_q;
        dat_meta_d = ps2_data;
        dat_sync_d = dat_meta_q;
    end

    // Filtered level flips only after FILTER_LEN consecutive disagreeing samples
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall_d     = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall_d = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Frame receiver: bits are taken on the filtered falling edge only
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;

        if (state_q == ST_IDLE || fall_q) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    parity_d = dat_sync_q;
                    state_d  = ST_STOP;
                end
                default: begin
                    if (dat_sync_q && (^{shift_q, parity_q})) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
            // Stalled mid-frame: drop the partial byte
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            shift_d   = 8'd0;
            tmo_d     = '0;
            err_d     = 1'b1;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q   <= 1'b1;
            clk_sync_q   <= 1'b1;
            dat_meta_q   <= 1'b1;
            dat_sync_q   <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            fall_q       <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_meta_q   <= clk_meta_d;
            clk_sync_q   <= clk_sync_d;
            dat_meta_q   <= dat_meta_d;
            dat_sync_q   <= dat_sync_d;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            fall_q       <= fall_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: rtl/ps2_arrow_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_arrow_decoder
// Description : Turns PS/2 extended arrow make codes into single fixed-length
//               up/down/left/right command pulses for the 2048 core.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_arrow_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int PULSE_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic frame_err
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_err;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          cmd_valid;
    dir_e          cmd_dir;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    dir_oh_q, dir_oh_d;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    // Prefix tracking: a command needs E0 without a preceding F0
    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        cmd_valid = 1'b0;
        cmd_dir   = DIR_UP;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            case (rx_byte)
                SC_EXT: ext_d = 1'b1;
                SC_BRK: brk_d = 1'b1;
                default: begin
                    if (ext_q && !brk_q) begin
                        case (rx_byte)
                            SC_UP:    begin cmd_valid = 1'b1; cmd_dir = DIR_UP;    end
                            SC_DOWN:  begin cmd_valid = 1'b1; cmd_dir = DIR_DOWN;  end
                            SC_LEFT:  begin cmd_valid = 1'b1; cmd_dir = DIR_LEFT;  end
                            SC_RIGHT: begin cmd_valid = 1'b1; cmd_dir = DIR_RIGHT; end
                            default:  cmd_valid = 1'b0;
                        endcase
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    // Pulse stretcher: commands arriving while a pulse is running are dropped
    always_comb begin
        cnt_d    = cnt_q;
        dir_oh_d = dir_oh_q;
        if (cmd_valid && cnt_q == '0) begin
            cnt_d    = CW'(PULSE_LEN);
            dir_oh_d = dir_onehot(cmd_dir);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                dir_oh_d = 4'b0000;
            end
        end
    end

    // Flag, counter and output registers; outputs come straight from flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            cnt_q    <= '0;
            dir_oh_q <= 4'b0000;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            cnt_q    <= cnt_d;
            dir_oh_q <= dir_oh_d;
        end
    end

    assign up        = dir_oh_q[DIR_UP];
    assign down      = dir_oh_q[DIR_DOWN];
    assign left      = dir_oh_q[DIR_LEFT];
    assign right     = dir_oh_q[DIR_RIGHT];
    assign frame_err = rx_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_arrow_decoder
// Description : Directed self-checking bench for ps2_arrow_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_arrow_decoder;
    import ps2_pkg::*;

    localparam int FILT = 8;
    localparam int TMO  = 1000;
    localparam int PL   = 4;
    localparam int HALF = 30;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic up, down, left, right, frame_err;

    int checks = 0;
    int errors = 0;

    ps2_arrow_decoder #(
        .FILTER_LEN (FILT),
        .TIMEOUT    (TMO),
        .PULSE_LEN  (PL)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Output observer: high-cycle counts, rise times, fall strobes, err cycles
    int         cyc       = 0;
    int         last_fall = 0;
    int         fall_cnt  = 0;
    int         err_cyc   = 0;
    int         multi     = 0;
    int         hi[4]        = '{default: 0};
    int         rise[4]      = '{default: 0};
    int         rise_fall[4] = '{default: 0};
    logic [3:0] prev      = 4'b0000;

    always @(negedge clk) begin
        logic [3:0] o;
        cyc++;
        if (u_dut.u_rx.fall_q) begin
            last_fall = cyc;
            fall_cnt++;
        end
        if (frame_err) err_cyc++;
        o = {right, left, down, up};
        if ($countones(o) > 1) multi++;
        for (int i = 0; i < 4; i++) begin
            if (o[i]) hi[i]++;
            if (o[i] && !prev[i]) begin
                rise[i]      = cyc;
                rise_fall[i] = last_fall;
            end
        end
        prev = o;
    end

    int b_hi[4];
    int b_err;
    int b_fall;

    task automatic snap();
        b_hi   = hi;
        b_err  = err_cyc;
        b_fall = fall_cnt;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a low and a high phase.
    // An optional 3-cycle low glitch is placed inside the high phase.
    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        cyc_wait(HALF / 2);
        ps2_clk = 1'b0;
        cyc_wait(HALF);
        ps2_clk = 1'b1;
        cyc_wait(HALF / 2);
        if (glitch) begin
            ps2_clk = 1'b0;
            cyc_wait(3);
            ps2_clk = 1'b1;
            cyc_wait(HALF / 2);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par);
        logic par;
        par = (~^b) ^ bad_par;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input int glitch_at);
        logic [10:0] f;
        f = frame_bits(b, bad_par);
        for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_at);
        ps2_data = 1'b1;
        cyc_wait(HALF);
    endtask

    int d_other;
    int seen;

    initial begin
        logic [10:0] f;

        // Reset state
        cyc_wait(5);
        chk("reset_outputs", int'({up, down, left, right, frame_err}), 0);
        chk("reset_rx_state", int'(u_dut.u_rx.state_q), int'(ST_IDLE));
        chk("reset_filt_level", int'(u_dut.u_rx.filt_q), 1);
        chk("reset_flags", int'({u_dut.ext_q, u_dut.brk_q}), 0);
        rst = 1'b0;
        cyc_wait(5);

        // E0 75 -> up, 4 cycles, starting 2 cycles after stop fall
        snap();
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        chk("up_len", hi[0] - b_hi[0], PL);
        chk("up_latency", rise[0] - rise_fall[0], 2);
        d_other = (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]) + (hi[3] - b_hi[3]);
        chk("up_others_quiet", d_other, 0);
        chk("up_no_err", err_cyc - b_err, 0);

        // Break sequence issues nothing, then E0 74 -> right
        snap();
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'hF0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        d_other = (hi[0] - b_hi[0]) + (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]) + (hi[3] - b_hi[3]);
        chk("break_no_output", d_other, 0);
        chk("break_flags_clear", int'({u_dut.ext_q, u_dut.brk_q}), 0);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        chk("right_len", hi[3] - b_hi[3], PL);

        // Non-extended 75 (keypad) issues nothing
        snap();
        send_frame(8'h75, 1'b0, -1);
        chk("keypad_no_up", hi[0] - b_hi[0], 0);

        // Bad parity -> one-cycle frame_err, then E0 6B -> left
        snap();
        send_frame(8'h6B, 1'b1, -1);
        chk("parity_err_strobe", err_cyc - b_err, 1);
        chk("parity_no_left", hi[2] - b_hi[2], 0);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h6B, 1'b0, -1);
        chk("left_len", hi[2] - b_hi[2], PL);

        // Bad stop bit -> frame_err
        snap();
        f = frame_bits(8'h72, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0);
        send_bit(1'b0, 1'b0);
        ps2_data = 1'b1;
        cyc_wait(HALF);
        chk("stop_err_strobe", err_cyc - b_err, 1);

        // Timeout after 4 data bits, then E0 72 -> down
        snap();
        f = frame_bits(8'hE0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
        ps2_data = 1'b1;
        cyc_wait(TMO + 10);
        chk("timeout_err_strobe", err_cyc - b_err, 1);
        chk("timeout_rx_idle", int'(u_dut.u_rx.state_q), int'(ST_IDLE));
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h72, 1'b0, -1);
        chk("down_len", hi[1] - b_hi[1], PL);
        chk("down_no_extra_err", err_cyc - b_err, 1);

        // Short clock glitches produce no fall, idle or mid-frame
        snap();
        ps2_data = 1'b1;
        ps2_clk  = 1'b0;
        cyc_wait(3);
        ps2_clk  = 1'b1;
        cyc_wait(20);
        chk("glitch_idle_no_fall", fall_cnt - b_fall, 0);
        chk("glitch_idle_no_err", err_cyc - b_err, 0);
        send_frame(8'hE0, 1'b0, 4);
        send_frame(8'h75, 1'b0, 6);
        chk("glitch_frame_falls", fall_cnt - b_fall, 22);
        chk("glitch_frame_up", hi[0] - b_hi[0], PL);

        // Typematic repeat: each make code is one move
        snap();
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h75, 1'b0, -1);
        chk("typematic_up", hi[0] - b_hi[0], 2 * PL);
        chk("never_multi_hot", multi, 0);

        // Reset during the left pulse drops it immediately
        send_frame(8'hE0, 1'b0, -1);
        f = frame_bits(8'h6B, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i], 1'b0);
        ps2_data = 1'b1;
        cyc_wait(HALF / 2);
        ps2_clk = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            if (left) seen = 1;
            else cyc_wait(1);
        end
        chk("rst_left_seen", seen, 1);
        rst = 1'b1;
        #1;
        chk("rst_async_left", int'(left), 0);
        ps2_clk = 1'b1;
        cyc_wait(3);
        chk("rst_outputs", int'({up, down, left, right, frame_err}), 0);
        chk("rst_flags", int'({u_dut.ext_q, u_dut.brk_q}), 0);
        rst = 1'b0;
        cyc_wait(5);

        // Decoder still works after the mid-pulse reset
        snap();
        send_frame(8'hE0, 1'b0, -1);
        send_frame(8'h74, 1'b0, -1);
        chk("post_rst_right", hi[3] - b_hi[3], PL);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
